// File: rtl/nand_cmd_seq.sv
// Command sequencer in front of the NAND PHY: expands one host request into the
// ordered CMD/ADDR/DATA/STAT op stream, runs tWB and status polling, reports completion.
module nand_cmd_seq #(
  parameter int PAGE_BYTES = 8192,
  parameter int TWB_CYC    = 10,
  parameter int POLL_GAP   = 16,
  parameter int MAX_POLLS  = 4096
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_chip,
  input  logic [23:0] req_row,
  input  logic [15:0] req_col,
  output logic        phy_valid,
  input  logic        phy_ready,
  output logic [2:0]  phy_type,
  output logic [7:0]  phy_byte,
  output logic [15:0] phy_len,
  output logic [1:0]  phy_cen,
  input  logic        sts_valid,
  input  logic [7:0]  sts_byte,
  output logic        done_valid,
  output logic [7:0]  done_status,
  output logic        done_timeout,
  output logic [3:0]  state_dbg
);

  // Handshakes: an item moves only on a cycle where valid & ready are both high;
  // a presented PHY op stays valid with type/byte/len unchanged until accepted.

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int CW = 16;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b01;
  localparam logic [1:0] OP_ERASE  = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  localparam logic [2:0] T_CMD   = 3'd0;
  localparam logic [2:0] T_ADDR  = 3'd1;
  localparam logic [2:0] T_WDATA = 3'd2;
  localparam logic [2:0] T_RDATA = 3'd3;
  localparam logic [2:0] T_STAT  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD1, S_ADDR, S_WBURST, S_CMD2, S_WAIT,
    S_POLL, S_STSWAIT, S_GAP, S_RDCMD, S_RBURST, S_DONE
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  kind;
    logic [7:0]  data;
    logic [15:0] len;
  } phy_op_t;

  state_t        state;
  phy_op_t       ph;
  logic [1:0]    op_q;
  logic [23:0]   row_q;
  logic [15:0]   col_q;
  logic [2:0]    addr_idx;
  logic [CW-1:0] cnt;
  logic [PW-1:0] polls;
  logic [2:0]    addr_last;

  function automatic phy_op_t op_cmd(input logic [7:0] b);
    phy_op_t o;
    o.valid = 1'b1;
    o.kind  = T_CMD;
    o.data  = b;
    o.len   = 16'd0;
    return o;
  endfunction

  function automatic phy_op_t op_addr(input logic [7:0] b);
    phy_op_t o;
    o.valid = 1'b1;
    o.kind  = T_ADDR;
    o.data  = b;
    o.len   = 16'd0;
    return o;
  endfunction

  function automatic phy_op_t op_xfer(input logic [2:0] kind);
    phy_op_t o;
    o.valid = 1'b1;
    o.kind  = kind;
    o.data  = 8'h00;
    o.len   = (kind == T_STAT) ? 16'd0 : 16'(PAGE_BYTES);
    return o;
  endfunction

  function automatic logic [7:0] first_cmd(input logic [1:0] op);
    case (op)
      OP_READ:  return 8'h00;
      OP_PROG:  return 8'h80;
      OP_ERASE: return 8'h60;
      default:  return 8'h70;
    endcase
  endfunction

  // Erase sends only the three row bytes, so its index is offset past the column bytes.
  function automatic logic [7:0] addr_byte(input logic [1:0] op, input logic [23:0] row,
                                           input logic [15:0] col, input logic [2:0] idx);
    logic [2:0] k;
    k = (op == OP_ERASE) ? idx + 3'd2 : idx;
    case (k)
      3'd0:    return col[7:0];
      3'd1:    return col[15:8];
      3'd2:    return row[7:0];
      3'd3:    return row[15:8];
      default: return row[23:16];
    endcase
  endfunction

  assign addr_last = (op_q == OP_ERASE) ? 3'd2 : 3'd4;
  assign req_ready = (state == S_IDLE);
  assign phy_valid = ph.valid;
  assign phy_type  = ph.kind;
  assign phy_byte  = ph.data;
  assign phy_len   = ph.len;
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      ph           <= '0;
      op_q         <= 2'b00;
      row_q        <= 24'd0;
      col_q        <= 16'd0;
      addr_idx     <= 3'd0;
      cnt          <= '0;
      polls        <= '0;
      phy_cen      <= 2'b11;
      done_valid   <= 1'b0;
      done_status  <= 8'h00;
      done_timeout <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          op_q         <= req_op;
          row_q        <= req_row;
          col_q        <= req_col;
          phy_cen      <= req_chip ? 2'b01 : 2'b10;
          done_status  <= 8'h00;
          done_timeout <= 1'b0;
          polls        <= '0;
          ph           <= op_cmd(first_cmd(req_op));
          state        <= S_CMD1;
        end
        S_CMD1: if (phy_ready) begin
          if (op_q == OP_STATUS) begin
            ph    <= op_xfer(T_STAT);
            state <= S_POLL;
          end else begin
            addr_idx <= 3'd0;
            ph       <= op_addr(addr_byte(op_q, row_q, col_q, 3'd0));
            state    <= S_ADDR;
          end
        end
        S_ADDR: if (phy_ready) begin
          if (addr_idx == addr_last) begin
            case (op_q)
              OP_PROG: begin
                ph    <= op_xfer(T_WDATA);
                state <= S_WBURST;
              end
              OP_ERASE: begin
                ph    <= op_cmd(8'hD0);
                state <= S_CMD2;
              end
              default: begin
                ph    <= op_cmd(8'h30);
                state <= S_CMD2;
              end
            endcase
          end else begin
            addr_idx <= addr_idx + 3'd1;
            ph       <= op_addr(addr_byte(op_q, row_q, col_q, addr_idx + 3'd1));
          end
        end
        S_WBURST: if (phy_ready) begin
          ph    <= op_cmd(8'h10);
          state <= S_CMD2;
        end
        S_CMD2: if (phy_ready) begin
          ph    <= '0;
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CW'(TWB_CYC - 1)) begin
            ph    <= op_cmd(8'h70);
            state <= S_POLL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // One state issues both halves of a poll: the 0x70 command, then the STAT read.
        S_POLL: if (phy_ready) begin
          if (ph.kind == T_CMD) begin
            ph <= op_xfer(T_STAT);
          end else begin
            ph    <= '0;
            state <= S_STSWAIT;
          end
        end
        S_STSWAIT: if (sts_valid) begin
          done_status <= sts_byte;
          if (op_q == OP_STATUS) begin
            done_valid <= 1'b1;
            state      <= S_DONE;
          end else if (sts_byte[6]) begin
            if (op_q == OP_READ) begin
              ph    <= op_cmd(8'h00);
              state <= S_RDCMD;
            end else begin
              done_valid <= 1'b1;
              state      <= S_DONE;
            end
          end else if (polls == PW'(MAX_POLLS - 1)) begin
            polls        <= polls + 1'b1;
            done_timeout <= 1'b1;
            done_valid   <= 1'b1;
            state        <= S_DONE;
          end else begin
            polls <= polls + 1'b1;
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == CW'(POLL_GAP - 1)) begin
            ph    <= op_cmd(8'h70);
            state <= S_POLL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RDCMD: if (phy_ready) begin
          ph    <= op_xfer(T_RDATA);
          state <= S_RBURST;
        end
        S_RBURST: if (phy_ready) begin
          ph         <= '0;
          done_valid <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          phy_cen <= 2'b11;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Bench for nand_cmd_seq: table of requests with a reference op-stream model,
// a PHY/status responder that scores every accepted op, plus reset/stray-status sequences.
module tb_nand_cmd_seq;

  localparam int PAGE = 8192;
  localparam int TWB  = 10;
  localparam int GAP  = 16;
  localparam int MAXP = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_chip = 1'b0;
  logic [23:0] req_row = 24'd0;
  logic [15:0] req_col = 16'd0;
  logic        phy_valid;
  logic        phy_ready = 1'b0;
  logic [2:0]  phy_type;
  logic [7:0]  phy_byte;
  logic [15:0] phy_len;
  logic [1:0]  phy_cen;
  logic        sts_valid = 1'b0;
  logic [7:0]  sts_byte = 8'h00;
  logic        done_valid;
  logic [7:0]  done_status;
  logic        done_timeout;
  logic [3:0]  state_dbg;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  nand_cmd_seq #(.PAGE_BYTES(PAGE), .TWB_CYC(TWB), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_chip(req_chip),
    .req_row(req_row), .req_col(req_col),
    .phy_valid(phy_valid), .phy_ready(phy_ready), .phy_type(phy_type), .phy_byte(phy_byte),
    .phy_len(phy_len), .phy_cen(phy_cen),
    .sts_valid(sts_valid), .sts_byte(sts_byte),
    .done_valid(done_valid), .done_status(done_status), .done_timeout(done_timeout),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [1:0]      op;
    logic            chip;
    logic [23:0]     row;
    logic [15:0]     col;
    logic [3:0][7:0] sts;
    logic [2:0]      n_sts;
    logic [2:0]      rmode;
    logic [7:0]      exp_status;
    logic            exp_timeout;
  } vec_t;

  // ---------------- scoreboard ----------------
  logic [26:0] exp_q[$];
  logic [8:0]  done_q[$];
  logic [7:0]  sts_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int cycle = 0;
  int ready_mode = 0;
  int req_seq = 0;
  int stray_req = 0;
  logic cur_chip = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  function automatic logic [26:0] enc(input logic [2:0] t, input logic [7:0] b, input logic [15:0] l);
    return {t, b, l};
  endfunction

  // Reference op stream for one request, derived from the command set of each operation.
  function automatic void push_ops(input vec_t v);
    int   polls;
    logic ok;
    ok = 1'b0;
    polls = int'(v.n_sts);
    for (int i = 0; i < int'(v.n_sts); i++) begin
      if (!ok && v.sts[i][6]) begin
        ok = 1'b1;
        polls = i + 1;
      end
    end
    if (v.op == 2'b11) begin
      exp_q.push_back(enc(3'd0, 8'h70, 16'd0));
      exp_q.push_back(enc(3'd4, 8'h00, 16'd0));
    end else begin
      exp_q.push_back(enc(3'd0, (v.op == 2'b00) ? 8'h00 : (v.op == 2'b01) ? 8'h80 : 8'h60, 16'd0));
      if (v.op != 2'b10) begin
        exp_q.push_back(enc(3'd1, v.col[7:0], 16'd0));
        exp_q.push_back(enc(3'd1, v.col[15:8], 16'd0));
      end
      exp_q.push_back(enc(3'd1, v.row[7:0], 16'd0));
      exp_q.push_back(enc(3'd1, v.row[15:8], 16'd0));
      exp_q.push_back(enc(3'd1, v.row[23:16], 16'd0));
      if (v.op == 2'b01) begin
        exp_q.push_back(enc(3'd2, 8'h00, 16'(PAGE)));
        exp_q.push_back(enc(3'd0, 8'h10, 16'd0));
      end else begin
        exp_q.push_back(enc(3'd0, (v.op == 2'b00) ? 8'h30 : 8'hD0, 16'd0));
      end
      for (int i = 0; i < polls; i++) begin
        exp_q.push_back(enc(3'd0, 8'h70, 16'd0));
        exp_q.push_back(enc(3'd4, 8'h00, 16'd0));
      end
      if (v.op == 2'b00 && ok) begin
        exp_q.push_back(enc(3'd0, 8'h00, 16'd0));
        exp_q.push_back(enc(3'd3, 8'h00, 16'(PAGE)));
      end
    end
    for (int i = 0; i < int'(v.n_sts); i++) sts_q.push_back(v.sts[i]);
    done_q.push_back({v.exp_status, v.exp_timeout});
  endfunction

  // PHY and status responder: drives ready/status at negedge, scores ops at negedge+1.
  initial begin : phy_model
    logic        stall;
    logic [26:0] held;
    logic [26:0] got;
    logic [26:0] last_op;
    logic [8:0]  d;
    int          sts_pend;
    int          stray_ack;
    int          last_acc;
    int          last_seq;
    stall = 1'b0; held = '0; last_op = '0;
    sts_pend = -1; stray_ack = 0; last_acc = 0; last_seq = -1;
    forever begin
      @(negedge CLK);
      cycle++;
      sts_valid = 1'b0;
      sts_byte  = 8'h00;
      if (!RST_N) sts_pend = -1;
      if (stray_ack != stray_req) begin
        stray_ack = stray_req;
        sts_valid = 1'b1;
        sts_byte  = 8'h55;
      end else if (sts_pend > 0) begin
        sts_pend--;
        if (sts_pend == 0) begin
          sts_pend = -1;
          if (sts_q.size() > 0) begin
            sts_valid = 1'b1;
            sts_byte  = sts_q.pop_front();
          end
        end
      end
      case (ready_mode)
        0:       phy_ready = 1'b1;
        1:       phy_ready = ~phy_ready;
        2:       phy_ready = 1'($urandom_range(0, 1));
        4:       phy_ready = !(phy_valid && phy_type == 3'd2);
        default: phy_ready = 1'b0;
      endcase
      #1;
      got = {phy_type, phy_byte, phy_len};
      if (stall && RST_N) begin
        check("stall_valid", 32'(phy_valid), 32'd1);
        check("stall_hold", 32'(got), 32'(held));
      end
      stall = RST_N && phy_valid && !phy_ready;
      held  = got;
      if (RST_N && phy_valid && phy_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_op: got %0h expected none", got);
        end else begin
          check("phy_op", 32'(got), 32'(exp_q.pop_front()));
        end
        check("phy_cen", 32'(phy_cen), cur_chip ? 32'd1 : 32'd2);
        if (got == enc(3'd0, 8'h70, 16'd0) && last_seq == req_seq) begin
          if (last_op[26:24] == 3'd0 &&
              (last_op[23:16] == 8'h30 || last_op[23:16] == 8'h10 || last_op[23:16] == 8'hD0))
            check("twb_gap", 32'(cycle - last_acc > TWB), 32'd1);
          if (last_op[26:24] == 3'd4)
            check("poll_gap", 32'(cycle - last_acc > GAP), 32'd1);
        end
        if (got[26:24] == 3'd4) sts_pend = 3;
        last_acc = cycle;
        last_op  = got;
        last_seq = req_seq;
      end
      if (RST_N && done_valid) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got status %0h expected none", done_status);
        end else begin
          d = done_q.pop_front();
          check("done_status", 32'(done_status), 32'(d[8:1]));
          check("done_timeout", 32'(done_timeout), 32'(d[0]));
          check("ops_drained", 32'(exp_q.size()), 32'd0);
        end
        done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v);
    int t;
    t = 0;
    @(negedge CLK); #2;
    while (!req_ready && t < 500) begin
      @(negedge CLK); #2;
      t++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    cur_chip   = v.chip;
    ready_mode = int'(v.rmode);
    req_seq++;
    push_ops(v);
    req_valid = 1'b1;
    req_op    = v.op;
    req_chip  = v.chip;
    req_row   = v.row;
    req_col   = v.col;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    req_row   = 24'($urandom);
    req_col   = 16'($urandom);
    @(negedge CLK); #2;
    check("busy_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    int t;
    start = done_cnt;
    send(v);
    t = 0;
    while (done_cnt == start && t < 3000) begin
      @(negedge CLK); #2;
      t++;
    end
    check("done_seen", 32'(done_cnt > start), 32'd1);
    @(negedge CLK); #2;
    check("done_pulse", 32'(done_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    check("status_hold", 32'(done_status), 32'(v.exp_status));
    check("cen_idle", 32'(phy_cen), 32'd3);
  endtask

  function automatic vec_t mkvec(input logic [1:0] op, input logic chip, input logic [23:0] row,
                                 input logic [15:0] col, input logic [31:0] sts, input logic [2:0] n,
                                 input logic [2:0] rmode, input logic [7:0] st, input logic to);
    vec_t v;
    v.op = op; v.chip = chip; v.row = row; v.col = col; v.sts = sts; v.n_sts = n;
    v.rmode = rmode; v.exp_status = st; v.exp_timeout = to;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  vec_t stall_vec;

  initial begin : main
    int start;
    int t;
    vecs[0] = mkvec(2'b00, 1'b0, 24'h012345, 16'h0000, 32'h000000E0, 3'd1, 3'd0, 8'hE0, 1'b0);
    vecs[1] = mkvec(2'b01, 1'b0, 24'h000010, 16'h0004, 32'h000000E1, 3'd1, 3'd1, 8'hE1, 1'b0);
    vecs[2] = mkvec(2'b10, 1'b1, 24'h00ABCD, 16'h0000, 32'h00C08080, 3'd3, 3'd0, 8'hC0, 1'b0);
    vecs[3] = mkvec(2'b00, 1'b1, 24'h3C5A7E, 16'h1234, 32'h80808080, 3'd4, 3'd2, 8'h80, 1'b1);
    vecs[4] = mkvec(2'b11, 1'b0, 24'h000000, 16'h0000, 32'h000000E0, 3'd1, 3'd0, 8'hE0, 1'b0);
    vecs[5] = mkvec(2'b01, 1'b1, 24'hFEDCBA, 16'h8001, 32'h00006020, 3'd2, 3'd2, 8'h60, 1'b0);
    stall_vec = mkvec(2'b01, 1'b1, 24'h000777, 16'h0010, 32'h000000E0, 3'd1, 3'd4, 8'hE0, 1'b0);

    repeat (3) @(negedge CLK);
    #2;
    check("rst_phy_valid", 32'(phy_valid), 32'd0);
    check("rst_phy_fields", 32'({phy_type, phy_byte, phy_len}), 32'd0);
    check("rst_cen", 32'(phy_cen), 32'd3);
    check("rst_done", 32'({done_valid, done_status, done_timeout}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK); #2;
    check("rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // A status return while idle must not disturb anything.
    stray_req++;
    repeat (2) @(negedge CLK);
    #2;
    check("stray_idle", 32'({req_ready, phy_valid, done_valid}), 32'h4);
    run_vec(vecs[4]);
    run_vec(vecs[5]);

    // Reset while a WDATA burst is stalled.
    send(stall_vec);
    t = 0;
    while (!(phy_valid && phy_type == 3'd2) && t < 200) begin
      @(negedge CLK); #2;
      t++;
    end
    check("wdata_seen", 32'(phy_valid && phy_type == 3'd2), 32'd1);
    repeat (2) @(negedge CLK);
    start = done_cnt;
    #3 RST_N = 1'b0;
    #1;
    check("abort_valid", 32'(phy_valid), 32'd0);
    check("abort_cen", 32'(phy_cen), 32'd3);
    check("abort_done", 32'(done_valid), 32'd0);
    ready_mode = 0;
    exp_q.delete();
    sts_q.delete();
    done_q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    #2;
    check("abort_no_done", 32'(done_cnt), 32'(start));
    run_vec(vecs[4]);

    repeat (5) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1);
  end

endmodule
